apb_requester: RTL
==================

Name: apb_requester

Overview:
APB requester (bus master) that drives the peripheral register interface used by the timer and other slaves: it generates sel, enable, write, addr and wdata, and samples rdata, ready and slverr. A simple valid/ready command port accepts one transfer at a time from the control logic. The block returns a single-cycle response pulse carrying the read data and the error status. A wait-state timeout bounds stalls from non-responding slaves.

Parameters:
addrWidth, 2, width of APB address and cmd_addr
dataWidth, 8, width of wdata/rdata and command/response data
timeoutCycles, 16, maximum ACCESS cycles before forced termination; 0 disables timeout

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  requester idle, command accepted when cmd_valid && cmd_ready at posedge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  addrWidth  transfer address
cmd_wdata  in  dataWidth  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  dataWidth  captured read data (0 for writes)
rsp_err  out  1  slverr sampled, or timeout
rsp_timeout  out  1  transfer ended by timeout
sel  out  1  APB select
enable  out  1  APB enable
write  out  1  APB direction
addr  out  addrWidth  APB address
wdata  out  dataWidth  APB write data
rdata  in  dataWidth  APB read data
ready  in  1  APB ready from slave
slverr  in  1  APB slave error

Behaviour:
- Reset (reset=0, async): state IDLE; sel=0, enable=0, write=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0. cmd_ready=1 while reset is held low.
- All APB outputs and response outputs are registered. cmd_ready = (state==IDLE), combinational from state.
- IDLE: on cmd_valid at posedge, latch cmd_write/cmd_addr/cmd_wdata into write/addr/wdata, set sel=1, enable=0, go SETUP. cmd_* are ignored while cmd_ready=0.
- SETUP: exactly one cycle; next posedge sets enable=1, clears the wait counter, goes ACCESS.
- ACCESS: sample ready at each posedge.
  - ready=1: rsp_rdata = rdata for reads, 0 for writes; rsp_err=slverr; rsp_timeout=0; rsp_valid=1; sel=0; enable=0; go IDLE.
  - ready=0 and counter==timeoutCycles-1 (timeoutCycles>0): rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, sel=0, enable=0, go IDLE.
  - Otherwise: counter++.
  - ready=1 takes priority over timeout on the same edge.
- Counter width: $clog2(timeoutCycles+1), minimum 1; it never wraps.
- addr, write and wdata are held stable from SETUP through the end of ACCESS. After completion they retain their last values.
- rsp_valid is high for exactly one cycle with no backpressure. rsp_rdata, rsp_err and rsp_timeout hold their values until the next completion.
- Latency with a zero-wait slave:
  - accept at edge N; sel=1 after N; enable=1 after N+1.
  - completion at N+2; rsp_valid=1 and cmd_ready=1 after N+2.
- Back-to-back: a command presented while rsp_valid=1 is accepted at N+3. sel is low for exactly one cycle between transfers. Minimum period is 3 cycles.
- Reset mid-transfer: sel and enable drop immediately (async), no rsp_valid is issued, and the command is lost. The first accept is possible on the first posedge after reset releases.
- slverr and rdata are ignored outside ACCESS and on edges where ready=0.

Test Plan:
1. Write addr=1, wdata=0x2A, slave ready=1 immediately -> sel high for 2 cycles, enable high for 1, addr=1/wdata=0x2A/write=1 stable, rsp_valid 1 cycle, rsp_err=0, rsp_rdata=0.
2. Read addr=2, slave holds ready=0 for 3 ACCESS cycles then ready=1 with rdata=0x55 -> enable high 4 cycles, rsp_rdata=0x55, rsp_err=0, addr stable throughout.
3. Write addr=2 with slave ready=1, slverr=1 -> rsp_err=1, rsp_timeout=0, rsp_valid 1 cycle.
4. timeoutCycles=16, ready held 0 -> after 16 ACCESS cycles sel/enable=0, rsp_err=1, rsp_timeout=1. Repeat with ready=1 on the 16th ACCESS edge -> normal completion, rsp_timeout=0.
5. cmd_valid held high with two queued reads (addr 0 then 1) -> second accepted on the rsp_valid cycle; sel low exactly 1 cycle between transfers; two rsp_valid pulses 3 cycles apart.
6. reset driven low during ACCESS -> sel, enable and rsp_valid go 0 without a clock edge, no response; after release cmd_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/apb_requester.sv
// APB requester: accepts one valid/ready command at a time and runs it as an
// APB SETUP/ACCESS transfer. It returns a one-cycle response with a wait-state timeout.
module apb_requester #(
    parameter int addrWidth     = 2,
    parameter int dataWidth     = 8,
    parameter int timeoutCycles = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [addrWidth-1:0] cmd_addr_i,
    input  logic [dataWidth-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    output logic [dataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic                 sel_o,
    output logic                 enable_o,
    output logic                 write_o,
    output logic [addrWidth-1:0] addr_o,
    output logic [dataWidth-1:0] wdata_o,
    input  logic [dataWidth-1:0] rdata_i,
    input  logic                 ready_i,
    input  logic                 slverr_i
);

    localparam int CntWidth = (timeoutCycles > 0 && $clog2(timeoutCycles + 1) > 1)
                              ? $clog2(timeoutCycles + 1) : 1;
    localparam int LastWait = (timeoutCycles > 0) ? timeoutCycles - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   waitCnt_q;
    logic                  sel_q;
    logic                  enable_q;
    logic                  write_q;
    logic [addrWidth-1:0]  addr_q;
    logic [dataWidth-1:0]  wdata_q;
    logic                  rspValid_q;
    logic [dataWidth-1:0]  rspRdata_q;
    logic                  rspErr_q;
    logic                  rspTimeout_q;
    logic                  timeoutHit;

    // A timeout of zero leaves the slave free to stall forever.
    assign timeoutHit = (timeoutCycles > 0) && (waitCnt_q == CntWidth'(LastWait));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            waitCnt_q    <= '0;
            sel_q        <= 1'b0;
            enable_q     <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b0;
            rspTimeout_q <= 1'b0;
        end else begin
            rspValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        write_q  <= cmd_write_i;
                        addr_q   <= cmd_addr_i;
                        wdata_q  <= cmd_wdata_i;
                        sel_q    <= 1'b1;
                        enable_q <= 1'b0;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    enable_q  <= 1'b1;
                    waitCnt_q <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave always wins over a timeout on the same edge.
                    if (ready_i) begin
                        rspValid_q   <= 1'b1;
                        rspRdata_q   <= write_q ? '0 : rdata_i;
                        rspErr_q     <= slverr_i;
                        rspTimeout_q <= 1'b0;
                        sel_q        <= 1'b0;
                        enable_q     <= 1'b0;
                        state_q      <= IDLE;
                    end else if (timeoutHit) begin
                        rspValid_q   <= 1'b1;
                        rspRdata_q   <= '0;
                        rspErr_q     <= 1'b1;
                        rspTimeout_q <= 1'b1;
                        sel_q        <= 1'b0;
                        enable_q     <= 1'b0;
                        state_q      <= IDLE;
                    end else if (waitCnt_q != '1) begin
                        waitCnt_q <= waitCnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    sel_q    <= 1'b0;
                    enable_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = rspValid_q;
    assign rsp_rdata_o   = rspRdata_q;
    assign rsp_err_o     = rspErr_q;
    assign rsp_timeout_o = rspTimeout_q;
    assign sel_o         = sel_q;
    assign enable_o      = enable_q;
    assign write_o       = write_q;
    assign addr_o        = addr_q;
    assign wdata_o       = wdata_q;

endmodule
